// File: rtl/ctrl.sv
// ctrl: multi-cycle RV32I main control, decode plus EXEC/MEM sequencer with branch flush bubble.
// Define CTRL_M_EXT_EN to decode M-extension ops on OP with func7=0000001.
module ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  input  logic       b_i,
  output logic [2:0] imm_type_o,
  output logic [1:0] inst_sel_o,
  output logic       reg_wr_o,
  output logic [3:0] alu_op_o,
  output logic [2:0] cmp_op_o,
  output logic [1:0] pc_sel_o,
  output logic       mem_sel_o,
  output logic [1:0] rd_sel_o,
  output logic       alu1_sel_o,
  output logic       alu2_sel_o,
  output logic [2:0] sel_type_o,
  output logic       we_o
);
  typedef enum logic {EXEC, MEM} state_t;
  state_t state_q, state_d;
  logic flush_q, flush_d;
  logic is_load, is_opimm, is_auipc, is_store, is_op, is_lui, is_br, is_jalr, is_jal;
  logic is_mem, taken;
  logic [3:0] base_op;
  assign is_load  = opcode_i == 5'b00000;
  assign is_opimm = opcode_i == 5'b00100;
  assign is_auipc = opcode_i == 5'b00101;
  assign is_store = opcode_i == 5'b01000;
  assign is_op    = opcode_i == 5'b01100;
  assign is_lui   = opcode_i == 5'b01101;
  assign is_br    = opcode_i == 5'b11000;
  assign is_jalr  = opcode_i == 5'b11001;
  assign is_jal   = opcode_i == 5'b11011;
  assign is_mem   = is_load | is_store;
  assign taken    = is_jal | is_jalr | (is_br & b_i);
  always_comb begin
    base_op = 4'b0000;
    case (func3_i)
      3'b000: base_op = (is_op && func7_i == 7'b0100000) ? 4'b0001 : 4'b0000;
      3'b001: base_op = 4'b0101;
      3'b010: base_op = 4'b1000;
      3'b011: base_op = 4'b1001;
      3'b100: base_op = 4'b0010;
      3'b101: base_op = func7_i[5] ? 4'b0111 : 4'b0110;
      3'b110: base_op = 4'b0011;
      3'b111: base_op = 4'b0100;
      default: base_op = 4'b0000;
    endcase
  end
`ifdef CTRL_M_EXT_EN
  // REM/REMU share the DIV/DIVU codes; func3[1] alone distinguishes them downstream
  logic [3:0] m_op;
  assign m_op = func3_i[2] ? {3'b111, func3_i[0]} : 4'b1010 + {2'b00, func3_i[1:0]};
  assign alu_op_o = (is_op && func7_i == 7'b0000001) ? m_op : (is_op | is_opimm) ? base_op : 4'b0000;
`else
  assign alu_op_o = (is_op | is_opimm) ? base_op : 4'b0000;
`endif
  assign imm_type_o = (is_lui | is_auipc) ? 3'b001 :
                      is_jal ? 3'b010 :
                      is_store ? 3'b011 :
                      (is_opimm | is_load | is_jalr) ? 3'b100 :
                      is_br ? 3'b101 : 3'b000;
  assign alu1_sel_o = is_jal | is_auipc | is_br;
  assign alu2_sel_o = ~is_op;
  assign cmp_op_o   = is_br ? func3_i : 3'b000;
  assign sel_type_o = is_mem ? func3_i : 3'b010;
  assign rd_sel_o   = is_load ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EXEC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end
  // a flush cycle executes a bubble, so it neither starts a memory access nor re-flushes
  always_comb begin
    state_d    = (state_q == EXEC && !flush_q && is_mem) ? MEM : EXEC;
    flush_d    = state_q == EXEC && !flush_q && taken;
    reg_wr_o   = 1'b0;
    we_o       = 1'b0;
    mem_sel_o  = 1'b0;
    inst_sel_o = 2'b00;
    pc_sel_o   = 2'b00;
    if (!rst_ni) begin
      inst_sel_o = 2'b01;
      pc_sel_o   = 2'b11;
    end else if (flush_q) begin
      inst_sel_o = 2'b01;
    end else if (state_q == MEM) begin
      mem_sel_o  = 1'b1;
      inst_sel_o = 2'b10;
      we_o       = is_store;
      reg_wr_o   = is_load;
    end else if (is_mem) begin
      pc_sel_o = 2'b10;
    end else begin
      reg_wr_o = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr;
      pc_sel_o = taken ? 2'b01 : 2'b00;
    end
  end
endmodule

// File: tb/tb_ctrl.sv
// tb_ctrl: directed-vector self-checking bench for ctrl.
module tb_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [4:0] opcode_i = 5'b01100;
  logic [2:0] func3_i = 3'b000;
  logic [6:0] func7_i = 7'b0000000;
  logic       b_i = 1'b0;
  logic [2:0] imm_type_o, cmp_op_o, sel_type_o;
  logic [1:0] inst_sel_o, pc_sel_o, rd_sel_o;
  logic [3:0] alu_op_o;
  logic       reg_wr_o, mem_sel_o, alu1_sel_o, alu2_sel_o, we_o;
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [4:0] LOAD = 5'b00000, OPIMM = 5'b00100, STORE = 5'b01000, OP = 5'b01100,
                         LUI = 5'b01101, BR = 5'b11000, JALR = 5'b11001, JAL = 5'b11011;
  ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .func3_i(func3_i), .func7_i(func7_i),
    .b_i(b_i), .imm_type_o(imm_type_o), .inst_sel_o(inst_sel_o), .reg_wr_o(reg_wr_o),
    .alu_op_o(alu_op_o), .cmp_op_o(cmp_op_o), .pc_sel_o(pc_sel_o), .mem_sel_o(mem_sel_o),
    .rd_sel_o(rd_sel_o), .alu1_sel_o(alu1_sel_o), .alu2_sel_o(alu2_sel_o),
    .sel_type_o(sel_type_o), .we_o(we_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic b);
    opcode_i = op;
    func3_i = f3;
    func7_i = f7;
    b_i = b;
    #1;
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    #2;
    chk("rst reg_wr", reg_wr_o, 0);
    chk("rst we", we_o, 0);
    chk("rst mem_sel", mem_sel_o, 0);
    chk("rst inst_sel", inst_sel_o, 2'b01);
    chk("rst pc_sel", pc_sel_o, 2'b11);
    chk("rst decode alu2", alu2_sel_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    drive(OP, 3'b000, 7'b0100000, 0);
    chk("sub alu_op", alu_op_o, 4'b0001);
    chk("sub alu2", alu2_sel_o, 0);
    chk("sub reg_wr", reg_wr_o, 1);
    chk("sub inst_sel", inst_sel_o, 2'b00);
    chk("sub pc_sel", pc_sel_o, 2'b00);
    drive(OP, 3'b000, 7'b0000000, 0);  chk("add", alu_op_o, 4'b0000);
    drive(OP, 3'b010, 7'b0000000, 0);  chk("slt", alu_op_o, 4'b1000);
    drive(OP, 3'b100, 7'b0000000, 0);  chk("xor", alu_op_o, 4'b0010);
    drive(OP, 3'b001, 7'b0000000, 0);  chk("sll", alu_op_o, 4'b0101);
    drive(OP, 3'b101, 7'b0000000, 0);  chk("srl", alu_op_o, 4'b0110);
    drive(OP, 3'b101, 7'b0100000, 0);  chk("sra", alu_op_o, 4'b0111);
    drive(OP, 3'b111, 7'b0000000, 0);  chk("and", alu_op_o, 4'b0100);
`ifdef CTRL_M_EXT_EN
    drive(OP, 3'b000, 7'b0000001, 0);  chk("mul", alu_op_o, 4'b1010);
    drive(OP, 3'b011, 7'b0000001, 0);  chk("mulhu", alu_op_o, 4'b1101);
    drive(OP, 3'b100, 7'b0000001, 0);  chk("div", alu_op_o, 4'b1110);
    drive(OP, 3'b111, 7'b0000001, 0);  chk("remu", alu_op_o, 4'b1111);
    chk("remu rd_sel", rd_sel_o, 2'b00);
`else
    drive(OP, 3'b000, 7'b0000001, 0);  chk("f7=1 add", alu_op_o, 4'b0000);
    drive(OP, 3'b100, 7'b0000001, 0);  chk("f7=1 xor", alu_op_o, 4'b0010);
`endif
    drive(OPIMM, 3'b000, 7'b0100000, 0);
    chk("addi alu_op", alu_op_o, 4'b0000);
    chk("addi imm", imm_type_o, 3'b100);
    chk("addi alu2", alu2_sel_o, 1);
    drive(LUI, 3'b000, 7'b0000000, 0);
    chk("lui imm", imm_type_o, 3'b001);
    chk("lui rd_sel", rd_sel_o, 2'b11);
    chk("lui reg_wr", reg_wr_o, 1);
    drive(STORE, 3'b010, 7'b0000000, 0);
    chk("sw alu_op", alu_op_o, 4'b0000);
    chk("sw imm", imm_type_o, 3'b011);
    chk("sw pc_sel", pc_sel_o, 2'b10);
    chk("sw exec we", we_o, 0);
    chk("sw sel_type", sel_type_o, 3'b010);
    tick();
    chk("sw mem mem_sel", mem_sel_o, 1);
    chk("sw mem we", we_o, 1);
    chk("sw mem inst_sel", inst_sel_o, 2'b10);
    chk("sw mem pc_sel", pc_sel_o, 2'b00);
    chk("sw mem reg_wr", reg_wr_o, 0);
    tick();
    drive(OP, 3'b000, 7'b0000000, 0);
    chk("post sw mem_sel", mem_sel_o, 0);
    chk("post sw reg_wr", reg_wr_o, 1);
    drive(LOAD, 3'b100, 7'b0000000, 0);
    chk("lbu alu1", alu1_sel_o, 0);
    chk("lbu rd_sel", rd_sel_o, 2'b01);
    chk("lbu sel_type", sel_type_o, 3'b100);
    chk("lbu exec reg_wr", reg_wr_o, 0);
    chk("lbu exec pc_sel", pc_sel_o, 2'b10);
    tick();
    chk("lbu mem reg_wr", reg_wr_o, 1);
    chk("lbu mem we", we_o, 0);
    chk("lbu mem mem_sel", mem_sel_o, 1);
    drive(OP, 3'b000, 7'b0000000, 0);
    tick();
    drive(JAL, 3'b000, 7'b0000000, 0);
    chk("jal alu1", alu1_sel_o, 1);
    chk("jal pc_sel", pc_sel_o, 2'b01);
    chk("jal imm", imm_type_o, 3'b010);
    chk("jal rd_sel", rd_sel_o, 2'b10);
    chk("jal reg_wr", reg_wr_o, 1);
    tick();
    drive(OP, 3'b000, 7'b0000000, 0);
    chk("flush inst_sel", inst_sel_o, 2'b01);
    chk("flush reg_wr", reg_wr_o, 0);
    chk("flush pc_sel", pc_sel_o, 2'b00);
    tick();
    chk("unflush inst_sel", inst_sel_o, 2'b00);
    chk("unflush reg_wr", reg_wr_o, 1);
    drive(JALR, 3'b000, 7'b0100000, 0);
    chk("jalr alu_op", alu_op_o, 4'b0000);
    chk("jalr pc_sel", pc_sel_o, 2'b01);
    chk("jalr imm", imm_type_o, 3'b100);
    tick();
    drive(OP, 3'b000, 7'b0000000, 0);
    chk("jalr flush", inst_sel_o, 2'b01);
    tick();
    drive(5'b10101, 3'b000, 7'b0000000, 0);
    chk("unk alu2", alu2_sel_o, 1);
    chk("unk reg_wr", reg_wr_o, 0);
    chk("unk imm", imm_type_o, 3'b000);
    chk("unk pc_sel", pc_sel_o, 2'b00);
    drive(BR, 3'b001, 7'b0000000, 0);
    chk("bne nt pc_sel", pc_sel_o, 2'b00);
    chk("bne cmp_op", cmp_op_o, 3'b001);
    chk("bne imm", imm_type_o, 3'b101);
    chk("bne alu1", alu1_sel_o, 1);
    chk("bne reg_wr", reg_wr_o, 0);
    tick();
    chk("bne nt no flush", inst_sel_o, 2'b00);
    drive(BR, 3'b001, 7'b0000000, 1);
    chk("bne t pc_sel", pc_sel_o, 2'b01);
    chk("bne t cmp_op", cmp_op_o, 3'b001);
    tick();
    drive(OP, 3'b000, 7'b0000000, 0);
    chk("bne t flush", inst_sel_o, 2'b01);
    tick();
    drive(STORE, 3'b000, 7'b0000000, 0);
    tick();
    chk("rst-mem we before", we_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst-mem we", we_o, 0);
    chk("rst-mem mem_sel", mem_sel_o, 0);
    chk("rst-mem pc_sel", pc_sel_o, 2'b11);
    drive(OP, 3'b000, 7'b0000000, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("after rst mem_sel", mem_sel_o, 0);
    chk("after rst inst_sel", inst_sel_o, 2'b00);
    chk("after rst reg_wr", reg_wr_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
